motor_setpoint_ramp: RTL and testbench

Slew-rate limiter that sits directly upstream of the PWM motor output stage. It holds a software-written target compare value per motor and produces the compare values that stage consumes. Once per PWM period, on the timer overflow tick, each output moves toward its clamped target by at most a programmable step. When disarmed, all outputs are forced to the minimum. The result is bounded, rate-limited motor commands with no step jumps.

---
 rtl/motor_setpoint_ramp.sv | 188 ++++++++++++++++++
 tb/tb_motor_setpoint_ramp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/motor_setpoint_ramp.sv
// ----------------------------------------------------------------------------
// motor_setpoint_ramp
//
// Slew-rate limiter placed ahead of the PWM motor output stage. Software
// writes a target compare value per motor. Once per PWM period (i_tick),
// a sweep walks all motors, one per cycle. Each output moves toward its
// clamped target by at most i_step. When disarmed, every output is forced
// to i_min.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   i_tick       one-cycle pulse per PWM period (timer overflow)
//   i_armed      1 = ramp toward target, 0 = force outputs to i_min
//   i_wr         target write strobe
//   i_wsel       target write index (values >= NUMBER_OF_MOTORS are ignored)
//   i_wdata      target compare value (unsigned)
//   i_min        lower clamp, also the disarmed output value
//   i_max        upper clamp
//   i_step       maximum change per tick per motor
//   o_compare    current compare values, motor k at [32k+31:32k]
//   o_busy       sweep in progress (SWEEP or DONE)
//   o_done       one-cycle pulse when a sweep completes
// ----------------------------------------------------------------------------
module motor_setpoint_ramp #(
    parameter int NUMBER_OF_MOTORS = 4,
    parameter int IDX_W = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_tick,
    input  logic                           i_armed,
    input  logic                           i_wr,
    input  logic [IDX_W-1:0]               i_wsel,
    input  logic [31:0]                    i_wdata,
    input  logic [31:0]                    i_min,
    input  logic [31:0]                    i_max,
    input  logic [31:0]                    i_step,
    output logic [32*NUMBER_OF_MOTORS-1:0] o_compare,
    output logic                           o_busy,
    output logic                           o_done
);

    // Sweep counter width is tied to the motor count, independent of IDX_W.
    localparam int CNT_W = (NUMBER_OF_MOTORS > 1) ? $clog2(NUMBER_OF_MOTORS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUMBER_OF_MOTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;

    logic [31:0] target_q [NUMBER_OF_MOTORS];
    logic [31:0] cur_q    [NUMBER_OF_MOTORS];

    logic [31:0] sel_cur;
    logic [31:0] sel_tgt;
    logic [31:0] upd_cur_d;

    // Clamp to [lo, hi]; the max() is applied last so that lo wins when
    // the limits are inverted.
    function automatic logic [31:0] clamp_target(input logic [31:0] tgt,
                                                 input logic [31:0] lo,
                                                 input logic [31:0] hi);
        logic [31:0] t;
        t = (tgt > hi) ? hi : tgt;
        t = (t < lo) ? lo : t;
        return t;
    endfunction

    // Move cur toward t by at most step. Each difference is only formed in
    // the direction known to be non-negative, and cur+step is only taken
    // when it stays below t, so nothing wraps.
    function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                                input logic [31:0] t,
                                                input logic [31:0] step);
        logic [31:0] res;
        res = cur;
        if (cur < t) begin
            res = ((t - cur) > step) ? (cur + step) : t;
        end else if (cur > t) begin
            res = ((cur - t) > step) ? (cur - step) : t;
        end
        return res;
    endfunction

    // Select the motor currently being processed.
    always_comb begin
        sel_cur = '0;
        sel_tgt = '0;
        for (int k = 0; k < NUMBER_OF_MOTORS; k++) begin
            if (32'(idx_q) == k) begin
                sel_cur = cur_q[k];
                sel_tgt = target_q[k];
            end
        end
        if (i_armed) begin
            upd_cur_d = step_toward(sel_cur, clamp_target(sel_tgt, i_min, i_max), i_step);
        end else begin
            upd_cur_d = i_min;
        end
    end

    // Next-state logic. A tick seen outside IDLE is remembered in a single
    // pending flag; the flag launches the next sweep straight out of DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (i_tick || pend_q) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            ST_SWEEP: begin
                if (i_tick) begin
                    pend_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                idx_d = '0;
                if (pend_q) begin
                    state_d = ST_SWEEP;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    if (i_tick) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            for (int k = 0; k < NUMBER_OF_MOTORS; k++) begin
                target_q[k] <= '0;
                cur_q[k]    <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            // The update reads target_q, so a same-cycle write to the motor
            // being processed takes effect on the next tick.
            for (int k = 0; k < NUMBER_OF_MOTORS; k++) begin
                if (i_wr && (32'(i_wsel) == k)) begin
                    target_q[k] <= i_wdata;
                end
                if ((state_q == ST_SWEEP) && (32'(idx_q) == k)) begin
                    cur_q[k] <= upd_cur_d;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUMBER_OF_MOTORS; k++) begin
            o_compare[32*k +: 32] = cur_q[k];
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_motor_setpoint_ramp.sv
module tb_motor_setpoint_ramp;

    localparam int N = 4;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_tick;
    logic            i_armed;
    logic            i_wr;
    logic [IW-1:0]   i_wsel;
    logic [31:0]     i_wdata;
    logic [31:0]     i_min;
    logic [31:0]     i_max;
    logic [31:0]     i_step;
    logic [32*N-1:0] o_compare;
    logic            o_busy;
    logic            o_done;

    int n_tests = 0;
    int n_fail  = 0;

    motor_setpoint_ramp #(
        .NUMBER_OF_MOTORS(N),
        .IDX_W(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_tick(i_tick),
        .i_armed(i_armed),
        .i_wr(i_wr),
        .i_wsel(i_wsel),
        .i_wdata(i_wdata),
        .i_min(i_min),
        .i_max(i_max),
        .i_step(i_step),
        .o_compare(o_compare),
        .o_busy(o_busy),
        .o_done(o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cmp(input int k);
        return o_compare[32*k +: 32];
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_tgt(input logic [IW-1:0] sel, input logic [31:0] data);
        i_wr    = 1'b1;
        i_wsel  = sel;
        i_wdata = data;
        step_clk();
        i_wr    = 1'b0;
    endtask

    // Pulse i_tick for one cycle (cycle T), wait for o_done with a bound,
    // then one more cycle so the FSM is back in IDLE. lat = T-relative
    // cycle in which o_done was seen.
    task automatic run_sweep(output int lat);
        i_tick = 1'b1;
        step_clk();
        i_tick = 1'b0;
        lat = 1;
        while (!o_done && lat < 20) begin
            step_clk();
            lat++;
        end
        chk("sweep_done", {31'd0, o_done}, 32'd1);
        step_clk();
    endtask

    initial begin
        int lat;
        logic [31:0] done_hist;
        logic [31:0] busy_hist;

        rst     = 1'b1;
        i_tick  = 1'b0;
        i_armed = 1'b0;
        i_wr    = 1'b0;
        i_wsel  = '0;
        i_wdata = '0;
        i_min   = '0;
        i_max   = '0;
        i_step  = '0;
        repeat (2) step_clk();

        // Reset state
        for (int k = 0; k < N; k++) chk($sformatf("rst_cmp%0d", k), cmp(k), 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        rst = 1'b0;

        // Disarmed sweep forces i_min; o_done in cycle T+N+1
        i_min  = 32'd100000;
        i_max  = 32'd200000;
        i_step = 32'd5000;
        i_tick = 1'b1;
        step_clk();
        i_tick = 1'b0;
        chk("busy_T1", {31'd0, o_busy}, 32'd1);
        lat = 1;
        while (!o_done && lat < 20) begin
            step_clk();
            lat++;
        end
        chk("done_latency", lat, N + 1);
        step_clk();
        chk("done_one_cycle", {31'd0, o_done}, 32'd0);
        chk("busy_after", {31'd0, o_busy}, 32'd0);
        for (int k = 0; k < N; k++) chk($sformatf("disarm_cmp%0d", k), cmp(k), 32'd100000);

        // Armed ramp-up of motor 0 toward 120000
        i_armed = 1'b1;
        wr_tgt(3'd0, 32'd120000);
        run_sweep(lat); chk("up1", cmp(0), 32'd105000);
        run_sweep(lat); chk("up2", cmp(0), 32'd110000);
        run_sweep(lat); chk("up3", cmp(0), 32'd115000);
        run_sweep(lat); chk("up4", cmp(0), 32'd120000);
        run_sweep(lat); chk("up_hold", cmp(0), 32'd120000);
        chk("m3_at_min", cmp(3), 32'd100000);

        // Clamp at i_max without overflow, then ramp down to i_min
        wr_tgt(3'd1, 32'hFFFF_FFFF);
        run_sweep(lat); chk("clamp_first", cmp(1), 32'd105000);
        repeat (21) run_sweep(lat);
        chk("clamp_hold", cmp(1), 32'd200000);
        wr_tgt(3'd1, 32'd0);
        run_sweep(lat); chk("down_first", cmp(1), 32'd195000);
        repeat (21) run_sweep(lat);
        chk("down_hold", cmp(1), 32'd100000);

        // Remainder steps in both directions
        wr_tgt(3'd2, 32'd103000);
        run_sweep(lat); chk("rem_up", cmp(2), 32'd103000);
        wr_tgt(3'd2, 32'd0);
        run_sweep(lat); chk("rem_down", cmp(2), 32'd100000);

        // Tick at T, again at T+2 (pending) and T+3 (dropped)
        i_tick = 1'b1;          // cycle T
        step_clk();
        i_tick = 1'b0;          // T+1
        step_clk();
        i_tick = 1'b1;          // T+2
        step_clk();             // T+3, tick still high
        step_clk();
        i_tick = 1'b0;          // T+4
        done_hist = '0;
        busy_hist = '0;
        for (int c = 0; c < 10; c++) begin
            done_hist[c] = o_done;
            busy_hist[c] = o_busy;
            step_clk();
        end
        // bit c = cycle T+4+c: done at T+5 and T+10, busy through T+10
        chk("b2b_done", done_hist, 32'h0000_0042);
        chk("b2b_busy", busy_hist, 32'h0000_007F);

        // Disarm mid-ramp with motor 2 at 150000, then re-arm
        wr_tgt(3'd2, 32'd190000);
        repeat (10) run_sweep(lat);
        chk("m2_mid", cmp(2), 32'd150000);
        i_armed = 1'b0;
        run_sweep(lat);
        chk("disarm_m2", cmp(2), 32'd100000);
        chk("disarm_m0", cmp(0), 32'd100000);
        i_armed = 1'b1;
        run_sweep(lat);
        chk("rearm_m2", cmp(2), 32'd105000);
        chk("rearm_m0", cmp(0), 32'd105000);

        // Out-of-range write index changes nothing
        wr_tgt(3'd4, 32'd77777);
        run_sweep(lat);
        chk("wsel_oor_m0", cmp(0), 32'd110000);
        chk("wsel_oor_m3", cmp(3), 32'd100000);

        // Inverted limits converge to i_min
        i_min  = 32'd150000;
        i_max  = 32'd120000;
        i_step = 32'd100000;
        run_sweep(lat);
        chk("inv_m0", cmp(0), 32'd150000);
        chk("inv_m1", cmp(1), 32'd150000);

        // Zero step while armed holds every output
        i_min  = 32'd100000;
        i_max  = 32'd200000;
        i_step = 32'd0;
        run_sweep(lat);
        chk("step0_m0", cmp(0), 32'd150000);

        // Reset asserted at T+2 of a sweep
        i_tick = 1'b1;          // T
        step_clk();
        i_tick = 1'b0;          // T+1
        step_clk();
        rst = 1'b1;             // T+2
        step_clk();             // T+3
        for (int k = 0; k < N; k++) chk($sformatf("rst_mid_cmp%0d", k), cmp(k), 32'd0);
        chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        step_clk();
        chk("rst_mid_idle", {31'd0, o_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
